// File: rtl/lane_scan_pkg.sv
// Shared types for the lane scan collector: scan FSM states, arbitration
// style selectors and the drained-record layout.
package lane_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_e;

    localparam int SCAN_RR   = 0;
    localparam int SCAN_PRIO = 1;

    // Record fields are sized for the widest legal configuration (16 lanes).
    localparam int REC_LANE_W = 4;
    localparam int REC_CNT_W  = 32;

    typedef struct packed {
        logic [REC_LANE_W-1:0] lane;
        logic [REC_CNT_W-1:0]  count;
        logic                  ovf;
    } lane_rec_t;

endpackage

// File: rtl/lane_scan_collector_lane_cnt.sv
// One lane's saturating event counter with a sticky overflow flag.
// A clear that coincides with an event restarts the count at 1.
module lane_cnt
    import lane_scan_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = evt ? CNT_W'(1) : '0;
            ovf_d   = 1'b0;
        end else if (evt) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/lane_scan_collector.sv
// Per-lane event counters drained one record at a time onto a valid/ready
// stream by an IDLE/SCAN/HOLD FSM; arbitration style chosen at elaboration.
module lane_scan_collector
    import lane_scan_pkg::*;
#(
    parameter int  NUM_LANES = 4,
    parameter int  CNT_W     = 8,
    parameter int  SCAN_MODE = SCAN_RR,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] lane_evt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANE_W-1:0]    out_lane,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    logic [CNT_W-1:0]     cnt [NUM_LANES];
    logic [NUM_LANES-1:0] lane_ovf;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] clr;

    scan_state_e       state_q, state_d;
    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic [LANE_W-1:0] grant_idx;
    logic              grant_found;
    lane_rec_t         rec_q, rec_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
        lane_cnt #(.CNT_W(CNT_W)) u_lane_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .evt   (lane_evt[i]),
            .clr   (clr[i]),
            .count (cnt[i]),
            .ovf   (lane_ovf[i])
        );
        assign pending[i] = (cnt[i] != '0);
    end

    if (SCAN_MODE == SCAN_PRIO) begin : gen_prio
        always_comb begin
            grant_found = 1'b0;
            grant_idx   = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (!grant_found && pending[k]) begin
                    grant_found = 1'b1;
                    grant_idx   = LANE_W'(k);
                end
            end
        end
    end else begin : gen_rr
        logic [LANE_W-1:0] cand;
        // Search wraps from the lane after the last grant.
        always_comb begin
            grant_found = 1'b0;
            grant_idx   = '0;
            cand        = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                cand = LANE_W'((int'(ptr_q) + 1 + k) % NUM_LANES);
                if (!grant_found && pending[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rec_d   = rec_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (|pending) state_d = SCAN;
            end
            SCAN: begin
                if (grant_found) begin
                    clr[grant_idx] = 1'b1;
                    rec_d.lane     = REC_LANE_W'(grant_idx);
                    rec_d.count    = REC_CNT_W'(cnt[grant_idx]);
                    rec_d.ovf      = lane_ovf[grant_idx];
                    ptr_d          = grant_idx;
                    state_d        = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) state_d = (|pending) ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= LANE_W'(NUM_LANES - 1);
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rec_q   <= rec_d;
        end
    end

    // Outputs come straight from flops, so out_ready never reaches them combinationally.
    assign out_valid = (state_q == HOLD);
    assign out_lane  = rec_q.lane[LANE_W-1:0];
    assign out_count = rec_q.count[CNT_W-1:0];
    assign out_ovf   = rec_q.ovf;

endmodule

// File: tb/tb_lane_scan_collector.sv
// Directed bench for lane_scan_collector: round-robin instance for the main
// sequence, a fixed-priority instance for the arbitration comparison.
module tb_lane_scan_collector;

    localparam int W = 2 + 8 + 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] lane_evt;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_lane;
    logic [7:0] out_count;
    logic       out_ovf;

    logic [3:0] p_evt;
    logic       p_ready;
    logic       p_valid;
    logic [1:0] p_lane;
    logic [7:0] p_count;
    logic       p_ovf;

    logic [W-1:0] exp_q[$];
    int total    = 0;
    int pass_cnt = 0;

    lane_scan_collector #(.NUM_LANES(4), .CNT_W(8), .SCAN_MODE(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lane_evt  (lane_evt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    lane_scan_collector #(.NUM_LANES(4), .CNT_W(8), .SCAN_MODE(1)) dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .lane_evt  (p_evt),
        .out_valid (p_valid),
        .out_ready (p_ready),
        .out_lane  (p_lane),
        .out_count (p_count),
        .out_ovf   (p_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] mk_rec(input int lane, input int cnt, input logic ovf);
        return {2'(lane), 8'(cnt), ovf};
    endfunction

    // Wait (bounded) for a record, compare against the scoreboard head, then accept it.
    task automatic get_rec(input string tag);
        logic [W-1:0] exp;
        int n = 0;
        while (!out_valid && n < 400) begin
            step();
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        chk(tag, 32'({out_lane, out_count, out_ovf}), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int nr;
        int np;
        rst_n     = 1'b0;
        lane_evt  = '0;
        out_ready = 1'b0;
        p_evt     = '0;
        p_ready   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lane",  32'(out_lane),  32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf",   32'(out_ovf),   32'd0);
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // Single event on lane 2: valid two edges after the sampling edge
        lane_evt = 4'b0100;
        step();
        lane_evt = '0;
        chk("single_lat0", 32'(out_valid), 32'd0);
        step();
        chk("single_lat1", 32'(out_valid), 32'd0);
        step();
        chk("single_lat2", 32'(out_valid), 32'd1);
        exp_q.push_back(mk_rec(2, 1, 1'b0));
        get_rec("single_rec");
        chk("single_idle0", 32'(out_valid), 32'd0);
        step();
        chk("single_idle1", 32'(out_valid), 32'd0);

        // Backpressure: lane 0 keeps counting while its previous record is held
        lane_evt = 4'b0001;
        step();
        lane_evt = '0;
        step();
        step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        lane_evt = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_frozen", 32'({out_valid, out_lane, out_count, out_ovf}), 32'({1'b1, 2'd0, 8'd1, 1'b0}));
        end
        lane_evt = '0;
        exp_q.push_back(mk_rec(0, 1, 1'b0));
        exp_q.push_back(mk_rec(0, 5, 1'b0));
        get_rec("bp_rec_a");
        get_rec("bp_rec_b");
        step();

        // Capture collision: lane 3 event on the draining edge
        lane_evt = 4'b1000;
        step();
        lane_evt = '0;
        step();
        lane_evt = 4'b1000;
        step();
        lane_evt = '0;
        exp_q.push_back(mk_rec(3, 1, 1'b0));
        exp_q.push_back(mk_rec(3, 1, 1'b0));
        get_rec("coll_rec_a");
        get_rec("coll_rec_b");
        step();

        // Saturation: lane 1 held for 300 cycles behind a lane 2 record in HOLD
        lane_evt = 4'b0100;
        step();
        lane_evt = '0;
        step();
        step();
        lane_evt = 4'b0010;
        for (int i = 0; i < 300; i++) step();
        lane_evt = '0;
        chk("sat_hold", 32'({out_valid, out_lane, out_count}), 32'({1'b1, 2'd2, 8'd1}));
        exp_q.push_back(mk_rec(2, 1, 1'b0));
        exp_q.push_back(mk_rec(1, 255, 1'b1));
        get_rec("sat_rec_l2");
        get_rec("sat_rec_l1");
        step();

        // Reset in the middle of a HOLD carrying count 3
        lane_evt = 4'b0100;
        step();
        lane_evt = '0;
        step();
        step();
        lane_evt = 4'b0001;
        step();
        step();
        step();
        lane_evt = '0;
        exp_q.push_back(mk_rec(2, 1, 1'b0));
        get_rec("rst_pre_l2");
        step();
        chk("rst_pre_hold", 32'({out_valid, out_lane, out_count}), 32'({1'b1, 2'd0, 8'd3}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_count", 32'(out_count), 32'd0);
        chk("rst_async_lane",  32'(out_lane),  32'd0);
        chk("rst_async_ovf",   32'(out_ovf),   32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_quiet", 32'(out_valid), 32'd0);
        end

        // Arbitration with every lane busy and the consumer always ready
        lane_evt  = '1;
        p_evt     = '1;
        out_ready = 1'b1;
        p_ready   = 1'b1;
        nr = 0;
        np = 0;
        for (int i = 0; i < 60 && (nr < 8 || np < 4); i++) begin
            step();
            if (out_valid && nr < 8) begin
                chk("rr_lane", 32'(out_lane), 32'(nr % 4));
                nr++;
            end
            if (p_valid && np < 4) begin
                chk("prio_lane", 32'(p_lane), 32'd0);
                np++;
            end
        end
        chk("rr_records", 32'(nr), 32'd8);
        chk("prio_records", 32'(np), 32'd4);
        lane_evt  = '0;
        p_evt     = '0;
        out_ready = 1'b0;
        p_ready   = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
